fb_write_arbiter: RTL

// - Owns the write port of the 24-bit dual-clock framebuffer RAM: fb_adr_w, fb_d, fb_we.
//   The VGA scan-out side only reads that RAM.
// - Shares the write port between two pixel requesters (A, B) using round-robin arbitration.
// - Contains a fill engine that clears or paints the whole 280x192 framebuffer, one pixel per cycle.
// - Sits between the pixel producers and the framebuffer.
// - CLOCK_50 also drives the RAM write clock.

---
 rtl/fb_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/fb_write_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer write path.
package fb_pkg;

    // Framebuffer geometry.
    localparam int unsigned FB_W     = 280;
    localparam int unsigned FB_H     = 192;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    // One pixel, {R[7:0], G[7:0], B[7:0]}.
    typedef logic [23:0] pixel_t;

    // Framebuffer address.
    typedef logic [15:0] fb_addr_t;

    // Write-port owner: requesters (IDLE) or the fill engine (FILL).
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fbw_state_t;

    // Identity of a pixel requester, as stored in the round-robin history.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // True when a write address lands inside the visible framebuffer.
    function automatic logic adr_in_range(input logic [31:0] adr, input int unsigned depth);
        return adr < depth;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win the last transfer is granted. The history only
// moves when the caller reports that the granted request was actually taken.
module rr_arb2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_id_t last_q, last_d;

    // Grant decode from the request pair and the last winner.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // History follows the grant only when a transfer completes.
    always_comb begin
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1] ? REQ_B : REQ_A;
        end
    end

    // Last-winner register; resets to B so A takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owner of the framebuffer RAM write port. Two pixel requesters share the
// port through a round-robin arbiter; a fill engine can take the port over to
// paint every pixel with one colour, one pixel per cycle. All RAM-facing
// outputs are registered, so a transfer in cycle N appears on the port in N+1.
module fb_write_arbiter #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned FB_DEPTH = fb_pkg::FB_W * fb_pkg::FB_H
) (
    input  logic              CLOCK_50,
    input  logic              reset,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_d,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_d,

    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,

    output logic              bad_adr,

    output logic [ADDR_W-1:0] fb_adr_w,
    output logic [DATA_W-1:0] fb_d,
    output logic              fb_we
);

    import fb_pkg::*;

    // Address of the final pixel; the fill counter stops here rather than
    // wrapping, which matters when the framebuffer fills the address space.
    localparam logic [ADDR_W-1:0] LastAdr = ADDR_W'(FB_DEPTH - 1);

    fbw_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;     // address of the fill write now on the port
    logic [DATA_W-1:0] color_q, color_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              bad_q, bad_d;

    logic [1:0]        gnt;
    logic              accept;
    logic              xfer;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_d;
    logic              sel_ok;

    rr_arb2 u_arb (
        .clk     (CLOCK_50),
        .reset   (reset),
        .req     ({b_valid, a_valid}),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Requesters are only served while idle; a fill request in the same cycle
    // takes priority, leaving the pending requests for after the fill.
    always_comb begin
        accept  = (state_q == IDLE) && !fill_start;
        a_ready = accept && gnt[0];
        b_ready = accept && gnt[1];
        xfer    = a_ready || b_ready;
        sel_adr = gnt[1] ? b_adr : a_adr;
        sel_d   = gnt[1] ? b_d : a_d;
        sel_ok  = adr_in_range(32'(sel_adr), FB_DEPTH);
    end

    // Next-state for the owner FSM, fill counter and output register stage.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        we_d    = 1'b0;
        adr_d   = adr_q;
        d_d     = d_q;
        bad_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    color_d = fill_color;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    adr_d   = '0;
                    d_d     = fill_color;
                end else if (xfer) begin
                    // An out-of-range request is still consumed, but only flagged.
                    if (sel_ok) begin
                        we_d  = 1'b1;
                        adr_d = sel_adr;
                        d_d   = sel_d;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (cnt_q == LastAdr) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    we_d  = 1'b1;
                    adr_d = cnt_q + ADDR_W'(1);
                    d_d   = color_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also aborts any fill in progress.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            d_q     <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            d_q     <= d_d;
            bad_q   <= bad_d;
        end
    end

    // Status outputs are decoded from registered state only.
    always_comb begin
        fill_busy = (state_q == FILL);
        fill_done = (state_q == FILL) && (cnt_q == LastAdr);
        bad_adr   = bad_q;
        fb_we     = we_q;
        fb_adr_w  = adr_q;
        fb_d      = d_q;
    end

endmodule
